// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module  : apb_arb_pkg
// Brief   : Shared types, defaults and helpers for the arbitrated APB master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int C_DEF_ADDR_W = 32;
  localparam int C_DEF_DATA_W = 32;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_arb_master_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; first request after 'last' wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  int w_cand;

  // Scan from the farthest offset down to the nearest so the closest
  // requester after 'last' is the final (winning) assignment.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_cand    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = (int'(last) + k) % NREQ;
      if (req[w_cand]) begin
        gnt         = '0;
        gnt[w_cand] = 1'b1;
        gnt_idx     = IW'(w_cand);
        gnt_valid   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_arb_master.sv
// ============================================================================
// Module  : apb_arb_master
// Brief   : Round-robin arbitrated APB master with wait-state timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = C_DEF_ADDR_W,
  parameter int DATA_W  = C_DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      paddr,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] C_WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] C_LAST_RST  = IW'(NREQ - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_last;
  logic [NREQ-1:0]   r_gnt_oh;
  logic [CW-1:0]     r_wait_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [NREQ-1:0]   w_arb_gnt;
  logic [IW-1:0]     w_arb_idx;
  logic              w_arb_valid;
  logic              w_grant;
  logic              w_access_done;
  logic              w_timeout;
  logic              w_finish;

  logic [ADDR_W-1:0] w_addr_arr  [NREQ];
  logic [DATA_W-1:0] w_wdata_arr [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign w_wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .last      (r_last),
    .gnt       (w_arb_gnt),
    .gnt_idx   (w_arb_idx),
    .gnt_valid (w_arb_valid)
  );

  // Handshake is suppressed while reset is asserted so no request is lost.
  assign w_grant       = presetn && (r_state == IDLE) && w_arb_valid;
  assign w_access_done = (r_state == ACCESS) && pready;
  assign w_timeout     = (r_state == ACCESS) && !pready && (r_wait_cnt == C_WAIT_LAST);
  assign w_finish      = w_access_done || w_timeout;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant)  w_state_nxt = SETUP;
      SETUP:                 w_state_nxt = ACCESS;
      ACCESS:  if (w_finish) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel      = (r_state != IDLE);
    penable   = (r_state == ACCESS);
    req_ready = w_grant ? w_arb_gnt : '0;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_last      <= C_LAST_RST;
      r_gnt_oh    <= '0;
      r_wait_cnt  <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last     <= w_arb_idx;
        r_gnt_oh   <= w_arb_gnt;
        r_paddr    <= w_addr_arr[w_arb_idx];
        r_pwdata   <= w_wdata_arr[w_arb_idx];
        r_pwrite   <= req_write[w_arb_idx];
        r_wait_cnt <= '0;
      end else if (r_state == ACCESS) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end

      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_finish) begin
        r_rsp_valid <= r_gnt_oh;
        r_rsp_err   <= w_access_done ? pslverr : 1'b1;
        r_rsp_rdata <= (w_access_done && !r_pwrite) ? prdata : '0;
      end
    end
  end

  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_arb_master.sv
// ============================================================================
// Module  : tb_apb_arb_master
// Brief   : Directed self-checking bench for apb_arb_master (NREQ=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  apb_arb_master #(
    .NREQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    req_valid = 2'b01;
    tick(); tick(); settle();
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
    n_cmp++; if ({psel, penable, pwrite, rsp_err} !== 4'b0) begin n_bad++; $display("FAIL rst_ctl: got %b expected 0000", {psel, penable, pwrite, rsp_err}); end
    n_cmp++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin n_bad++; $display("FAIL rst_data: got %h expected 0", {paddr, pwdata, rsp_rdata}); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp: got %b expected 00", rsp_valid); end
    req_valid = 2'b00;
    presetn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h10;
    settle();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL rd_idle_psel: got %b expected 0", psel); end
    tick(); req_valid = 2'b00; settle();
    n_cmp++; if ({psel, penable} !== 2'b10) begin n_bad++; $display("FAIL rd_setup: got %b expected 10", {psel, penable}); end
    n_cmp++; if (paddr !== 32'h10) begin n_bad++; $display("FAIL rd_paddr: got %h expected 10", paddr); end
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    tick(); settle();
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL rd_access: got %b expected 11", {psel, penable}); end
    tick(); pready = 1'b0; prdata = '0; settle();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rd_rsp: got %b expected 01", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata: got %h expected deadbeef", rsp_rdata); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b expected 0", rsp_err); end
    n_cmp++; if (psel !== 1'b0) begin n_bad++; $display("FAIL rd_done_psel: got %b expected 0", psel); end
  endtask

  task automatic test_write_wait();
    int pen_cnt;
    pen_cnt = 0;
    prdata = 32'hFFFF_FFFF;
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h4; req_wdata[63:32] = 32'h55;
    settle();
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL wr_ready: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00; settle();
    n_cmp++; if ({psel, penable, pwrite, pwdata} !== {3'b101, 32'h55}) begin n_bad++; $display("FAIL wr_setup: got %h expected 5_00000055", {psel, penable, pwrite, pwdata}); end
    for (int i = 0; i < 4; i++) begin
      tick(); pready = (i == 3); settle();
      if (penable) pen_cnt++;
      n_cmp++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'h4, 32'h55}) begin n_bad++; $display("FAIL wr_hold%0d: got %h expected 1_00000004_00000055", i, {pwrite, paddr, pwdata}); end
    end
    tick(); pready = 1'b0; settle();
    n_cmp++; if (pen_cnt !== 4) begin n_bad++; $display("FAIL wr_penable_cycles: got %0d expected 4", pen_cnt); end
    n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h0}) begin n_bad++; $display("FAIL wr_rsp: got %h expected 4_00000000", {rsp_valid, rsp_err, rsp_rdata}); end
    prdata = '0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[31:0] = 32'h20; req_addr[63:32] = 32'h24;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (req_ready !== exp_g[i]) begin n_bad++; $display("FAIL b2b_ready%0d: got %b expected %b", i, req_ready, exp_g[i]); end
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== exp_g[i-1]) begin n_bad++; $display("FAIL b2b_rsp%0d: got %b expected %b", i, rsp_valid, exp_g[i-1]); end
        n_cmp++; if (rsp_rdata !== 32'hA0 + 32'(i - 1)) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rsp_rdata, 32'hA0 + 32'(i - 1)); end
      end
      tick();
      if (i == 3) req_valid = 2'b00;
      settle();
      n_cmp++; if (paddr !== ((exp_g[i] == 2'b01) ? 32'h20 : 32'h24)) begin n_bad++; $display("FAIL b2b_paddr%0d: got %h", i, paddr); end
      tick(); pready = 1'b1; prdata = 32'hA0 + 32'(i);
      tick(); pready = 1'b0;
    end
    settle();
    n_cmp++; if ({rsp_valid, req_ready} !== 4'b1000) begin n_bad++; $display("FAIL b2b_last: got %b expected 1000", {rsp_valid, req_ready}); end
    n_cmp++; if (rsp_rdata !== 32'hA3) begin n_bad++; $display("FAIL b2b_last_rdata: got %h expected a3", rsp_rdata); end
    prdata = '0;
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    prdata = 32'h77;
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h30;
    settle();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL to_ready: got %b expected 01", req_ready); end
    while (!seen && n < 40) begin
      tick(); req_valid = 2'b00; n++; settle();
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    n_cmp++; if (n !== 18) begin n_bad++; $display("FAIL to_latency: got %0d expected 18", n); end
    n_cmp++; if ({rsp_valid, rsp_err} !== 3'b011) begin n_bad++; $display("FAIL to_rsp: got %b expected 011", {rsp_valid, rsp_err}); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h expected 0", rsp_rdata); end
    n_cmp++; if ({psel, penable} !== 2'b00) begin n_bad++; $display("FAIL to_idle: got %b expected 00", {psel, penable}); end
    prdata = '0;
  endtask

  task automatic test_slverr();
    req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h40;
    settle();
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL se_ready: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234;
    tick(); pready = 1'b0; pslverr = 1'b0; prdata = '0; settle();
    n_cmp++; if ({rsp_valid, rsp_err} !== 3'b101) begin n_bad++; $display("FAIL se_rsp: got %b expected 101", {rsp_valid, rsp_err}); end
    n_cmp++; if (rsp_rdata !== 32'h1234) begin n_bad++; $display("FAIL se_rdata: got %h expected 1234", rsp_rdata); end
    req_valid = 2'b01;
    settle();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL se_next_ready: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); pready = 1'b1;
    tick(); pready = 1'b0; settle();
    n_cmp++; if ({rsp_valid, rsp_err} !== 3'b010) begin n_bad++; $display("FAIL se_clean_rsp: got %b expected 010", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h50; req_wdata[63:32] = 32'h99;
    settle();
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL rm_ready: got %b expected 10", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); settle();
    n_cmp++; if (penable !== 1'b1) begin n_bad++; $display("FAIL rm_access: got %b expected 1", penable); end
    presetn = 1'b0; pready = 1'b1;
    tick(); settle();
    n_cmp++; if ({psel, penable, pwrite, rsp_err, req_ready, rsp_valid} !== 8'b0) begin n_bad++; $display("FAIL rm_ctl: got %b expected 0", {psel, penable, pwrite, rsp_err, req_ready, rsp_valid}); end
    n_cmp++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin n_bad++; $display("FAIL rm_data: got %h expected 0", {paddr, pwdata, rsp_rdata}); end
    tick(); pready = 1'b0; settle();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rm_no_rsp: got %b expected 00", rsp_valid); end
    presetn = 1'b1; req_valid = 2'b11; req_write = 2'b00;
    settle();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL rm_prio: got %b expected 01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); pready = 1'b1;
    tick(); pready = 1'b0; settle();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL rm_after_rsp: got %b expected 01", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
